// File: rtl/fp_max_reduce.sv
//==============================================================================
// Module      : fp_max_reduce
// Description : Streaming max/min reduction over a frame of IEEE half or
//               single precision floats. Once per frame it reports the
//               extreme value, its zero-based index and the element count
//               minus one. Frames longer than MAX_LEN are cut short and
//               flagged with out_trunc.
//               Optional NaN handling: define FP_MAX_REDUCE_NAN_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fp_max_reduce #(
  parameter string PRECISION = "HALF",
  parameter int    BITS      = 16,
  parameter int    MAX_LEN   = 256,
  parameter int    IDX_BITS  = 8,
  parameter string MODE      = "MAX"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITS-1:0]     in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITS-1:0]     out_data,
  output logic [IDX_BITS-1:0] out_index,
  output logic [IDX_BITS-1:0] out_count,
  output logic                out_trunc
`ifdef FP_MAX_REDUCE_NAN_EN
  ,
  output logic                nan_seen
`endif
);

  // Mantissa width selects where the exponent field sits for NaN detection.
  localparam int c_man_bits = (PRECISION == "SINGLE") ? 23 : 10;
  localparam bit c_is_max   = (MODE == "MAX");

  localparam logic [BITS-1:0]     c_sign_mask = BITS'(1) << (BITS - 1);
  localparam logic [IDX_BITS-1:0] c_last_cnt  = IDX_BITS'(MAX_LEN - 1);
  localparam logic [IDX_BITS-1:0] c_cnt_one   = IDX_BITS'(1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_accum = 2'd1;
  localparam logic [1:0] c_st_hold  = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                w_accept;
  logic [BITS-1:0]     r_data;
  logic [IDX_BITS-1:0] r_index;
  logic [IDX_BITS-1:0] r_count;
  logic                r_trunc;
  logic [IDX_BITS-1:0] w_cnt_inc;
  logic                w_hit_len;
  logic [BITS-1:0]     w_new_key;
  logic [BITS-1:0]     w_held_key;
  logic                w_key_wins;
  logic                w_new_nan;
  logic                w_wins;

  assign w_accept  = in_valid & in_ready;
  assign w_cnt_inc = r_count + c_cnt_one;
  assign w_hit_len = (w_cnt_inc == c_last_cnt);

  // Ordered keys: flipping the sign bit of positives and inverting negatives
  // makes an unsigned compare follow float order (-0 sits just below +0).
  assign w_new_key  = in_data[BITS-1] ? ~in_data : (in_data ^ c_sign_mask);
  assign w_held_key = r_data[BITS-1]  ? ~r_data  : (r_data  ^ c_sign_mask);

  // Strict compare so ties keep the earlier element.
  assign w_key_wins = c_is_max ? (w_new_key > w_held_key) : (w_new_key < w_held_key);

  assign w_new_nan = (&in_data[BITS-2:c_man_bits]) & (|in_data[c_man_bits-1:0]);

`ifdef FP_MAX_REDUCE_NAN_EN
  logic r_held_nan;
  logic r_nan_seen;

  // A NaN never wins; any real value displaces a NaN that was held only
  // because it opened the frame.
  assign w_wins   = ~w_new_nan & (r_held_nan | w_key_wins);
  assign nan_seen = r_nan_seen;

  // NaN bookkeeping: held-value NaN flag and frame-wide NaN flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held_nan <= 1'b0;
      r_nan_seen <= 1'b0;
    end else if (w_accept) begin
      if (r_state == c_st_idle) begin
        r_held_nan <= w_new_nan;
        r_nan_seen <= w_new_nan;
      end else begin
        if (w_wins) begin
          r_held_nan <= 1'b0;
        end
        r_nan_seen <= r_nan_seen | w_new_nan;
      end
    end
  end
`else
  // NaNs are ordered by key like any other pattern; the classification is
  // only consumed when NaN handling is built in.
  logic w_unused_nan;
  assign w_unused_nan = w_new_nan;
  assign w_wins       = w_key_wins;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: frame start, accumulation, result hold.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          w_state_nxt = in_last ? c_st_hold : c_st_accum;
        end
      end
      c_st_accum: begin
        if (w_accept && (in_last || w_hit_len)) begin
          w_state_nxt = c_st_hold;
        end
      end
      c_st_hold: begin
        if (out_ready) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Handshake outputs: input closed while the result is held or in reset.
  always_comb begin
    in_ready  = ~rst & (r_state != c_st_hold);
    out_valid = (r_state == c_st_hold);
  end

  // Running extreme value, its index, element count and truncation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_index <= '0;
      r_count <= '0;
      r_trunc <= 1'b0;
    end else if (w_accept) begin
      if (r_state == c_st_idle) begin
        r_data  <= in_data;
        r_index <= '0;
        r_count <= '0;
        r_trunc <= 1'b0;
      end else begin
        r_count <= w_cnt_inc;
        r_trunc <= ~in_last & w_hit_len;
        if (w_wins) begin
          r_data  <= in_data;
          r_index <= w_cnt_inc;
        end
      end
    end
  end

  assign out_data  = r_data;
  assign out_index = r_index;
  assign out_count = r_count;
  assign out_trunc = r_trunc;

endmodule

`default_nettype wire

// File: tb/tb_fp_max_reduce.sv
//==============================================================================
// Module      : tb_fp_max_reduce
// Description : Self-checking bench for fp_max_reduce. Three instances:
//               0 = HALF MAX, MAX_LEN 4; 1 = SINGLE MIN; 2 = HALF MIN.
//               Directed frames plus randomized frames checked against a
//               sign/magnitude ranking model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fp_max_reduce;

`ifdef FP_MAX_REDUCE_NAN_EN
  localparam bit c_nan_en = 1'b1;
`else
  localparam bit c_nan_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iv;
  logic [2:0]  il;
  logic [2:0]  ordy;
  logic [15:0] d0_i;
  logic [31:0] d1_i;
  logic [15:0] d2_i;
  wire  [2:0]  ir;
  wire  [2:0]  ov;
  wire  [2:0]  tr;
  wire  [15:0] d0_o;
  wire  [31:0] d1_o;
  wire  [15:0] d2_o;
  wire  [1:0]  x0, c0;
  wire  [3:0]  x1, c1, x2, c2;
`ifdef FP_MAX_REDUCE_NAN_EN
  wire  [2:0]  ns;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_max_reduce #(.PRECISION("HALF"), .BITS(16), .MAX_LEN(4), .IDX_BITS(2), .MODE("MAX")) u_h4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(d0_i), .in_last(il[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(d0_o), .out_index(x0), .out_count(c0),
    .out_trunc(tr[0])
`ifdef FP_MAX_REDUCE_NAN_EN
    , .nan_seen(ns[0])
`endif
  );

  fp_max_reduce #(.PRECISION("SINGLE"), .BITS(32), .MAX_LEN(16), .IDX_BITS(4), .MODE("MIN")) u_s (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(d1_i), .in_last(il[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(d1_o), .out_index(x1), .out_count(c1),
    .out_trunc(tr[1])
`ifdef FP_MAX_REDUCE_NAN_EN
    , .nan_seen(ns[1])
`endif
  );

  fp_max_reduce #(.PRECISION("HALF"), .BITS(16), .MAX_LEN(16), .IDX_BITS(4), .MODE("MIN")) u_hmin (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(d2_i), .in_last(il[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(d2_o), .out_index(x2), .out_count(c2),
    .out_trunc(tr[2])
`ifdef FP_MAX_REDUCE_NAN_EN
    , .nan_seen(ns[2])
`endif
  );

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_single(input int k);
    return (k == 1);
  endfunction

  function automatic bit is_max(input int k);
    return (k == 0);
  endfunction

  // Float order as a signed integer: positives by magnitude, negatives by
  // negated magnitude, with -0 just below +0.
  function automatic longint rank(input logic [31:0] v, input bit single);
    longint mag;
    bit     s;
    if (single) begin
      s   = v[31];
      mag = longint'(v[30:0]);
    end else begin
      s   = v[15];
      mag = longint'(v[14:0]);
    end
    return s ? (-mag - 1) : mag;
  endfunction

  function automatic bit is_nan(input logic [31:0] v, input bit single);
    if (single) return (v[30:23] == 8'hff) && (v[22:0] != 23'd0);
    return (v[14:10] == 5'h1f) && (v[9:0] != 10'd0);
  endfunction

  // Reference: first element with the extreme rank; NaNs skipped when enabled.
  task automatic model(input int k, input logic [31:0] q[$], output logic [31:0] d,
                       output int idx, output bit nan);
    int best;
    best = -1;
    nan  = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      bit n;
      n   = is_nan(q[i], is_single(k));
      nan = nan | n;
      if (!(c_nan_en && n)) begin
        if (best < 0) best = i;
        else if (is_max(k) ? (rank(q[i], is_single(k)) > rank(q[best], is_single(k)))
                           : (rank(q[i], is_single(k)) < rank(q[best], is_single(k))))
          best = i;
      end
    end
    if (best < 0) best = 0;
    idx = best;
    d   = q[best];
  endtask

  task automatic set_data(input int k, input logic [31:0] d);
    case (k)
      0:       d0_i = d[15:0];
      1:       d1_i = d;
      default: d2_i = d[15:0];
    endcase
  endtask

  task automatic get_out(input int k, output logic [31:0] d, output int x, output int c);
    case (k)
      0:       begin d = {16'd0, d0_o}; x = int'(x0); c = int'(c0); end
      1:       begin d = d1_o;          x = int'(x1); c = int'(c1); end
      default: begin d = {16'd0, d2_o}; x = int'(x2); c = int'(c2); end
    endcase
  endtask

  // Offer one element; returns just after the accepting edge.
  task automatic push(input int k, input logic [31:0] d, input bit last, input bit gaps);
    int tries;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    iv[k] = 1'b1;
    il[k] = last;
    set_data(k, d);
    tries = 0;
    while (!ir[k] && tries < 40) begin
      @(negedge clk);
      tries++;
    end
    check_eq($sformatf("in_ready_%0d", k), {63'd0, ir[k]}, 64'd1);
    @(posedge clk); #1;
    iv[k] = 1'b0;
    il[k] = 1'b0;
  endtask

  task automatic send_frame(input int k, input logic [31:0] q[$], input bit with_last,
                            input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      push(k, q[i], with_last && (i == q.size() - 1), gaps);
    end
  endtask

  // Wait for the result, check it, hold it for a while, then release it.
  task automatic expect_res(input int k, input logic [31:0] de, input int xe, input int ce,
                            input bit te, input bit ne, input int hold);
    int          w;
    logic [31:0] d;
    int          x, c;
    string       t;
    t = $sformatf("u%0d", k);
    w = 0;
    @(negedge clk);
    while (!ov[k] && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq({t, "_latency"}, 64'(w), 64'd0);
    check_eq({t, "_out_valid"}, {63'd0, ov[k]}, 64'd1);
    get_out(k, d, x, c);
    check_eq({t, "_data"}, 64'(d), 64'(de));
    check_eq({t, "_index"}, 64'(x), 64'(xe));
    check_eq({t, "_count"}, 64'(c), 64'(ce));
    check_eq({t, "_trunc"}, {63'd0, tr[k]}, {63'd0, te});
`ifdef FP_MAX_REDUCE_NAN_EN
    check_eq({t, "_nan_seen"}, {63'd0, ns[k]}, {63'd0, ne});
`else
    if (ne) begin end
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      get_out(k, d, x, c);
      check_eq({t, "_hold_data"}, 64'(d), 64'(de));
      check_eq({t, "_hold_index"}, 64'(x), 64'(xe));
      check_eq({t, "_hold_valid"}, {63'd0, ov[k]}, 64'd1);
    end
    check_eq({t, "_hold_in_ready"}, {63'd0, ir[k]}, 64'd0);
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    @(negedge clk);
    check_eq({t, "_release_valid"}, {63'd0, ov[k]}, 64'd0);
    check_eq({t, "_release_ready"}, {63'd0, ir[k]}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] de;
    int          xe;
    bit          ne;
    int          len;
    bit          wl;
    logic [31:0] d;
    int          x, c;

    rst  = 1'b1;
    iv   = '0;
    il   = '0;
    ordy = '0;
    d0_i = '0;
    d1_i = '0;
    d2_i = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      get_out(k, d, x, c);
      check_eq($sformatf("u%0d_rst_ready", k), {63'd0, ir[k]}, 64'd0);
      check_eq($sformatf("u%0d_rst_valid", k), {63'd0, ov[k]}, 64'd0);
      check_eq($sformatf("u%0d_rst_data", k), 64'(d), 64'd0);
      check_eq($sformatf("u%0d_rst_idx_cnt", k), 64'(x + c), 64'd0);
      check_eq($sformatf("u%0d_rst_trunc", k), {63'd0, tr[k]}, 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // HALF MAX frame, result held with out_ready low for 10 cycles.
    q = '{32'h3C00, 32'h4000, 32'hBC00, 32'h3800};
    send_frame(0, q, 1'b1, 1'b0);
    expect_res(0, 32'h4000, 1, 3, 1'b0, 1'b0, 10);

    // SINGLE MIN with a tie: the first of the equal minima is kept.
    q = '{32'h3F800000, 32'hC0000000, 32'hC0000000};
    send_frame(1, q, 1'b1, 1'b0);
    expect_res(1, 32'hC0000000, 1, 2, 1'b0, 1'b0, 0);

    // Signed zeros: +0 ranks above -0.
    q = '{32'h8000, 32'h0000};
    send_frame(0, q, 1'b1, 1'b0);
    expect_res(0, 32'h0000, 1, 1, 1'b0, 1'b0, 0);
    send_frame(2, q, 1'b1, 1'b0);
    expect_res(2, 32'h8000, 0, 1, 1'b0, 1'b0, 0);

    // Truncation at MAX_LEN=4; the fifth element opens a new frame.
    q = '{32'h3C00, 32'h3C01, 32'h3C02, 32'h3C03};
    send_frame(0, q, 1'b0, 1'b0);
    expect_res(0, 32'h3C03, 3, 3, 1'b1, 1'b0, 0);
    push(0, 32'h4400, 1'b1, 1'b0);
    expect_res(0, 32'h4400, 0, 0, 1'b0, 1'b0, 0);

    // NaN at the head of a frame.
    q = '{32'h7E00, 32'h3C00};
    send_frame(0, q, 1'b1, 1'b0);
    if (c_nan_en) expect_res(0, 32'h3C00, 1, 1, 1'b0, 1'b1, 0);
    else          expect_res(0, 32'h7E00, 0, 1, 1'b0, 1'b1, 0);

    // Reset mid-frame discards the partial result immediately.
    push(0, 32'h3C00, 1'b0, 1'b0);
    push(0, 32'h4000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    get_out(0, d, x, c);
    check_eq("midrst_data", 64'(d), 64'd0);
    check_eq("midrst_idx_cnt", 64'(x + c), 64'd0);
    check_eq("midrst_valid", {63'd0, ov[0]}, 64'd0);
    check_eq("midrst_ready", {63'd0, ir[0]}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    push(0, 32'h4200, 1'b1, 1'b0);
    expect_res(0, 32'h4200, 0, 0, 1'b0, 1'b0, 0);

    // Randomized frames, with repeated values to exercise ties.
    for (int k = 0; k < 3; k++) begin
      for (int f = 0; f < 10; f++) begin
        len = (k == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 12));
        wl  = !((k == 0) && (len == 4) && ($urandom_range(0, 2) == 0));
        q   = {};
        for (int i = 0; i < len; i++) begin
          if (i > 0 && $urandom_range(0, 3) == 0) q.push_back(q[$urandom_range(0, i - 1)]);
          else if (is_single(k))                   q.push_back($urandom);
          else                                     q.push_back({16'd0, 16'($urandom)});
        end
        model(k, q, de, xe, ne);
        send_frame(k, q, wl, 1'b1);
        expect_res(k, de, xe, len - 1, !wl, ne, int'($urandom_range(0, 2)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
